mmsp430_trace_capture: RTL and testbench

Parametrised execution-trace capture stage for the MSP430 debug subsystem. Takes one retired-instruction trace record per cycle, filters it by a selectable mode, and timestamps qualifying events. Buffers them in a DEPTH-entry FIFO and presents them to the debug trace packetiser over a valid/ready handshake. Events that arrive when the buffer is full are dropped and counted, and the count is attached to the next stored event.

---
 rtl/mmsp430_trace_capture.sv | 133 +++++++++++++
 tb/tb_mmsp430_trace_capture.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmsp430_trace_capture.sv
// rtl/mmsp430_trace_capture.sv - filtered, timestamped retired-instruction trace FIFO
module mmsp430_trace_capture #(
   parameter int XLEN  = 32,
   parameter int RAW   = 5,
   parameter int DEPTH = 8,
   parameter int TSW   = 16,
   parameter int LW    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [1:0]               mode,
   input  logic                     trace_valid,
   input  logic [31:0]              trace_insn,
   input  logic [XLEN-1:0]          trace_pc,
   input  logic                     trace_jb,
   input  logic                     trace_jal,
   input  logic                     trace_jr,
   input  logic [XLEN-1:0]          trace_jbtarget,
   input  logic                     trace_wben,
   input  logic [RAW-1:0]           trace_wbreg,
   input  logic [XLEN-1:0]          trace_wbdata,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [TSW-1:0]           out_ts,
   output logic [31:0]              out_insn,
   output logic [XLEN-1:0]          out_pc,
   output logic [XLEN-1:0]          out_target,
   output logic [XLEN-1:0]          out_wbdata,
   output logic [RAW-1:0]           out_wbreg,
   output logic [3:0]               out_flags,
   output logic [LW-1:0]            out_lost,
   output logic [$clog2(DEPTH):0]   fill
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = AW + 1;
   localparam int EW = TSW + 32 + 3 * XLEN + RAW + 4 + LW;

   logic [TSW-1:0] ts;
   logic [LW-1:0]  lost;
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [FW-1:0]  fill_q;
   logic [FW-1:0]  fill_next;
   logic           valid_q;
   logic [EW-1:0]  mem [DEPTH];
   logic [EW-1:0]  entry;
   logic           is_cf;
   logic           match;
   logic           q;
   logic           pop;
   logic           push;
   logic           drop;

   // Filter the incoming record by the currently selected mode
   always_comb begin
      match = 1'b0;
      is_cf = trace_jb | trace_jal | trace_jr;
      case (mode)
         2'b00:   match = 1'b1;
         2'b01:   match = is_cf;
         2'b10:   match = trace_wben;
         default: match = is_cf | trace_wben;
      endcase
   end

   assign q     = enable & trace_valid & match;
   assign pop   = valid_q & out_ready;
   // A full FIFO still takes the new record when the head leaves in the same cycle
   assign push  = q & ((fill_q < FW'(DEPTH)) | pop);
   assign drop  = q & ~push;
   assign entry = {ts, trace_insn, trace_pc, trace_jbtarget, trace_wbdata, trace_wbreg,
                   trace_jb, trace_jal, trace_jr, trace_wben, lost};

   // Occupancy after this cycle's push/pop
   always_comb begin
      fill_next = fill_q;
      case ({push, pop})
         2'b10:   fill_next = fill_q + FW'(1);
         2'b01:   fill_next = fill_q - FW'(1);
         default: fill_next = fill_q;
      endcase
   end

   // Free-running timestamp, frozen while capture is disabled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts <= '0;
      end else if (enable) begin
         ts <= ts + TSW'(1);
      end
   end

   // Saturating dropped-event count, handed to the next stored entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lost <= '0;
      end else if (push) begin
         lost <= '0;
      end else if (drop && (lost != {LW{1'b1}})) begin
         lost <= lost + LW'(1);
      end
   end

   // FIFO storage, pointers, occupancy and registered head-valid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         fill_q  <= '0;
         valid_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= entry;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         fill_q  <= fill_next;
         valid_q <= (fill_next != '0);
      end
   end

   assign out_valid = valid_q;
   assign fill      = fill_q;
   assign {out_ts, out_insn, out_pc, out_target, out_wbdata, out_wbreg, out_flags, out_lost} = mem[rd_ptr];

endmodule

// File: tb/tb_mmsp430_trace_capture.sv
// tb/tb_mmsp430_trace_capture.sv - directed vector bench for mmsp430_trace_capture
module tb_mmsp430_trace_capture;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [1:0]  mode;
   logic        trace_valid;
   logic [31:0] trace_insn;
   logic [31:0] trace_pc;
   logic        trace_jb;
   logic        trace_jal;
   logic        trace_jr;
   logic [31:0] trace_jbtarget;
   logic        trace_wben;
   logic [4:0]  trace_wbreg;
   logic [31:0] trace_wbdata;
   logic        out_ready;

   logic        out_valid;
   logic [15:0] out_ts;
   logic [31:0] out_insn;
   logic [31:0] out_pc;
   logic [31:0] out_target;
   logic [31:0] out_wbdata;
   logic [4:0]  out_wbreg;
   logic [3:0]  out_flags;
   logic [7:0]  out_lost;
   logic [3:0]  fill;

   logic        s_valid;
   logic [15:0] s_ts;
   logic [31:0] s_insn;
   logic [31:0] s_pc;
   logic [31:0] s_target;
   logic [31:0] s_wbdata;
   logic [4:0]  s_wbreg;
   logic [3:0]  s_flags;
   logic [1:0]  s_lost;
   logic [3:0]  s_fill;

   int n_cmp;
   int n_fail;

   mmsp430_trace_capture u_dut (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode),
      .trace_valid(trace_valid), .trace_insn(trace_insn), .trace_pc(trace_pc),
      .trace_jb(trace_jb), .trace_jal(trace_jal), .trace_jr(trace_jr),
      .trace_jbtarget(trace_jbtarget), .trace_wben(trace_wben),
      .trace_wbreg(trace_wbreg), .trace_wbdata(trace_wbdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts),
      .out_insn(out_insn), .out_pc(out_pc), .out_target(out_target),
      .out_wbdata(out_wbdata), .out_wbreg(out_wbreg), .out_flags(out_flags),
      .out_lost(out_lost), .fill(fill)
   );

   mmsp430_trace_capture #(.LW(2)) u_small (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode),
      .trace_valid(trace_valid), .trace_insn(trace_insn), .trace_pc(trace_pc),
      .trace_jb(trace_jb), .trace_jal(trace_jal), .trace_jr(trace_jr),
      .trace_jbtarget(trace_jbtarget), .trace_wben(trace_wben),
      .trace_wbreg(trace_wbreg), .trace_wbdata(trace_wbdata),
      .out_valid(s_valid), .out_ready(out_ready), .out_ts(s_ts),
      .out_insn(s_insn), .out_pc(s_pc), .out_target(s_target),
      .out_wbdata(s_wbdata), .out_wbreg(s_wbreg), .out_flags(s_flags),
      .out_lost(s_lost), .fill(s_fill)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_b4;
      logic        en;
      logic [1:0]  mode;
      logic        tv;
      logic [31:0] pc;
      logic [3:0]  fl;
      logic        rdy;
      logic        e_ov;
      logic [3:0]  e_fill;
      logic [15:0] e_ts;
      logic [31:0] e_pc;
      logic [3:0]  e_fl;
      logic [7:0]  e_lost;
   } vec_t;

   vec_t vt [14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en, input logic [1:0] m, input logic tv,
                        input logic [31:0] pc, input logic [3:0] fl, input logic rdy);
      enable         = en;
      mode           = m;
      trace_valid    = tv;
      trace_pc       = pc;
      trace_insn     = {16'h4000, pc[15:0]};
      trace_wbdata   = 32'hD000_0000 | pc;
      trace_wbreg    = 5'd7;
      trace_jbtarget = 32'h200;
      {trace_jb, trace_jal, trace_jr, trace_wben} = fl;
      out_ready      = rdy;
   endtask

   task automatic apply_reset();
      drive(1'b0, 2'b00, 1'b0, 32'h0, 4'h0, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic push_rec(input logic [31:0] pc, input logic rdy);
      drive(1'b1, 2'b00, 1'b1, pc, 4'h0, rdy);
      step();
   endtask

   task automatic idle(input logic rdy);
      drive(1'b1, 2'b00, 1'b0, 32'h0, 4'h0, rdy);
      step();
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst    = 1'b1;
      drive(1'b0, 2'b00, 1'b0, 32'h0, 4'h0, 1'b0);

      // rst_b4 en mode tv pc fl rdy | ov fill ts pc fl lost
      vt[0]  = '{1'b1, 1'b1, 2'd0, 1'b1, 32'h100, 4'h0, 1'b1, 1'b1, 4'd1, 16'd0, 32'h100, 4'h0, 8'd0};
      vt[1]  = '{1'b0, 1'b1, 2'd0, 1'b1, 32'h102, 4'h0, 1'b1, 1'b1, 4'd1, 16'd1, 32'h102, 4'h0, 8'd0};
      vt[2]  = '{1'b0, 1'b1, 2'd0, 1'b1, 32'h104, 4'h0, 1'b1, 1'b1, 4'd1, 16'd2, 32'h104, 4'h0, 8'd0};
      vt[3]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h106, 4'h0, 1'b1, 1'b0, 4'd0, 16'd0, 32'h0,   4'h0, 8'd0};
      vt[4]  = '{1'b1, 1'b1, 2'd1, 1'b1, 32'h010, 4'h0, 1'b1, 1'b0, 4'd0, 16'd0, 32'h0,   4'h0, 8'd0};
      vt[5]  = '{1'b0, 1'b1, 2'd1, 1'b1, 32'h012, 4'h8, 1'b1, 1'b1, 4'd1, 16'd1, 32'h012, 4'h8, 8'd0};
      vt[6]  = '{1'b0, 1'b1, 2'd1, 1'b1, 32'h014, 4'h0, 1'b1, 1'b0, 4'd0, 16'd0, 32'h0,   4'h0, 8'd0};
      vt[7]  = '{1'b0, 1'b1, 2'd1, 1'b1, 32'h016, 4'h8, 1'b1, 1'b1, 4'd1, 16'd3, 32'h016, 4'h8, 8'd0};
      vt[8]  = '{1'b0, 1'b1, 2'd1, 1'b1, 32'h018, 4'h1, 1'b1, 1'b0, 4'd0, 16'd0, 32'h0,   4'h0, 8'd0};
      vt[9]  = '{1'b1, 1'b1, 2'd2, 1'b1, 32'h020, 4'h1, 1'b1, 1'b1, 4'd1, 16'd0, 32'h020, 4'h1, 8'd0};
      vt[10] = '{1'b0, 1'b1, 2'd3, 1'b1, 32'h022, 4'h4, 1'b1, 1'b1, 4'd1, 16'd1, 32'h022, 4'h4, 8'd0};
      vt[11] = '{1'b0, 1'b1, 2'd2, 1'b1, 32'h024, 4'h2, 1'b1, 1'b0, 4'd0, 16'd0, 32'h0,   4'h0, 8'd0};
      vt[12] = '{1'b0, 1'b0, 2'd0, 1'b1, 32'h026, 4'h0, 1'b1, 1'b0, 4'd0, 16'd0, 32'h0,   4'h0, 8'd0};
      vt[13] = '{1'b0, 1'b1, 2'd0, 1'b1, 32'h028, 4'h0, 1'b1, 1'b1, 4'd1, 16'd3, 32'h028, 4'h0, 8'd0};

      apply_reset();
      chk("reset_valid", 64'(out_valid), 64'd0);
      chk("reset_fill",  64'(fill),      64'd0);
      chk("reset_pc",    64'(out_pc),    64'd0);
      chk("reset_ts",    64'(out_ts),    64'd0);
      chk("reset_lost",  64'(out_lost),  64'd0);

      for (int i = 0; i < 14; i++) begin
         if (vt[i].rst_b4) apply_reset();
         drive(vt[i].en, vt[i].mode, vt[i].tv, vt[i].pc, vt[i].fl, vt[i].rdy);
         step();
         chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vt[i].e_ov));
         chk($sformatf("vec%0d_fill", i),  64'(fill),      64'(vt[i].e_fill));
         if (vt[i].e_ov) begin
            chk($sformatf("vec%0d_ts", i),     64'(out_ts),     64'(vt[i].e_ts));
            chk($sformatf("vec%0d_pc", i),     64'(out_pc),     64'(vt[i].e_pc));
            chk($sformatf("vec%0d_flags", i),  64'(out_flags),  64'(vt[i].e_fl));
            chk($sformatf("vec%0d_lost", i),   64'(out_lost),   64'(vt[i].e_lost));
            chk($sformatf("vec%0d_target", i), 64'(out_target), 64'h200);
            chk($sformatf("vec%0d_insn", i),   64'(out_insn),   64'({16'h4000, vt[i].e_pc[15:0]}));
            chk($sformatf("vec%0d_wbdata", i), 64'(out_wbdata), 64'(32'hD000_0000 | vt[i].e_pc));
            chk($sformatf("vec%0d_wbreg", i),  64'(out_wbreg),  64'd7);
         end
      end

      // Overflow: 11 records into a stalled 8-deep FIFO, then push while full and popping
      apply_reset();
      for (int i = 0; i < 11; i++) push_rec(32'h300 + 32'(2 * i), 1'b0);
      chk("ovf_fill_sat", 64'(fill),   64'd8);
      chk("ovf_head_pc",  64'(out_pc), 64'h300);
      push_rec(32'h400, 1'b1);
      chk("full_pushpop_fill",  64'(fill),      64'd8);
      chk("full_pushpop_valid", 64'(out_valid), 64'd1);
      for (int k = 1; k < 8; k++) begin
         chk($sformatf("drain%0d_pc", k),   64'(out_pc),   64'(32'h300 + 32'(2 * k)));
         chk($sformatf("drain%0d_ts", k),   64'(out_ts),   64'(k));
         chk($sformatf("drain%0d_lost", k), 64'(out_lost), 64'd0);
         idle(1'b1);
      end
      chk("ninth_pc",   64'(out_pc),   64'h400);
      chk("ninth_ts",   64'(out_ts),   64'd11);
      chk("ninth_lost", 64'(out_lost), 64'd3);
      idle(1'b1);
      chk("drained_valid", 64'(out_valid), 64'd0);
      chk("drained_fill",  64'(fill),      64'd0);

      // Five drops: narrow counter saturates at 3, wide one reads 5; next entry clean
      apply_reset();
      for (int i = 0; i < 13; i++) push_rec(32'h300 + 32'(2 * i), 1'b0);
      push_rec(32'h500, 1'b1);
      push_rec(32'h502, 1'b1);
      for (int k = 0; k < 6; k++) idle(1'b1);
      chk("sat_small_pc",   64'(s_pc),     64'h500);
      chk("sat_small_lost", 64'(s_lost),   64'd3);
      chk("sat_wide_lost",  64'(out_lost), 64'd5);
      chk("sat_ts",         64'(out_ts),   64'd13);
      idle(1'b1);
      chk("after_sat_pc",   64'(s_pc),     64'h502);
      chk("after_sat_lost", 64'(s_lost),   64'd0);

      // Asynchronous reset with 4 entries buffered and 2 events lost
      apply_reset();
      for (int i = 0; i < 10; i++) push_rec(32'h700 + 32'(2 * i), 1'b0);
      for (int k = 0; k < 4; k++) idle(1'b1);
      chk("prerst_fill", 64'(fill), 64'd4);
      out_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", 64'(out_valid), 64'd0);
      chk("async_rst_fill",  64'(fill),      64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      push_rec(32'h600, 1'b1);
      chk("postrst_valid", 64'(out_valid), 64'd1);
      chk("postrst_pc",    64'(out_pc),    64'h600);
      chk("postrst_ts",    64'(out_ts),    64'd0);
      chk("postrst_lost",  64'(out_lost),  64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
